// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch load controller: state encoding, window
// counter width and helpers for converting cycle counts into counter loads.
package latch_ctrl_pkg;

    localparam int COUNT_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        PULSE = ST_PULSE,
        HOLD  = ST_HOLD
    } state_t;

    // The counter runs down to zero inclusive, so an N-cycle window loads N-1.
    function automatic logic [COUNT_W-1:0] window_load(input int cycles);
        return COUNT_W'(cycles - 1);
    endfunction

    function automatic bit cycles_legal(input int cycles);
        return (cycles >= 1) && (cycles <= 255);
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter shared by the setup, pulse and hold windows.
// Stops at zero instead of wrapping.
module cycle_down_counter
    import latch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               en,
    output logic               zero
);

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/latch_load_controller.sv
// Drives a transparent latch's D and enable with cycle-counted setup, pulse
// and hold windows, and checks the latch readback at the end of each pulse.
module latch_load_controller
    import latch_ctrl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] latch_D,
    output logic             latch_enable,
    input  logic [WIDTH-1:0] latch_Q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    if (WIDTH < 1) begin : g_bad_width
        $error("latch_load_controller: WIDTH must be at least 1");
    end
    if (!cycles_legal(SETUP_CYC)) begin : g_bad_setup
        $error("latch_load_controller: SETUP_CYC out of range 1..255");
    end
    if (!cycles_legal(PULSE_CYC)) begin : g_bad_pulse
        $error("latch_load_controller: PULSE_CYC out of range 1..255");
    end
    if (!cycles_legal(HOLD_CYC)) begin : g_bad_hold
        $error("latch_load_controller: HOLD_CYC out of range 1..255");
    end

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   data_next;
    logic               enable_reg;
    logic               enable_next;
    logic               done_reg;
    logic               done_next;
    logic               err_reg;
    logic               err_next;

    logic               cnt_load;
    logic [COUNT_W-1:0] cnt_value;
    logic               cnt_en;
    logic               cnt_zero;

    cycle_down_counter u_window_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .en         (cnt_en),
        .zero       (cnt_zero)
    );

    // Readiness is gated by rst directly so a word offered during reset is never taken.
    assign in_ready = (state_reg == IDLE) && !rst;

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        enable_next = enable_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        cnt_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                enable_next = 1'b0;
                if (in_valid && in_ready) begin
                    data_next  = in_data;
                    state_next = SETUP;
                    cnt_load   = 1'b1;
                    cnt_value  = window_load(SETUP_CYC);
                end
            end
            SETUP: begin
                enable_next = 1'b0;
                if (cnt_zero) begin
                    state_next  = PULSE;
                    enable_next = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_value   = window_load(PULSE_CYC);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PULSE: begin
                enable_next = 1'b1;
                if (cnt_zero) begin
                    // Q is sampled on the same edge that drops enable, while the latch is still transparent.
                    if (latch_Q != data_reg) begin
                        err_next = 1'b1;
                    end
                    state_next  = HOLD;
                    enable_next = 1'b0;
                    cnt_load    = 1'b1;
                    cnt_value   = window_load(HOLD_CYC);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                enable_next = 1'b0;
                if (cnt_zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                enable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            enable_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            enable_reg <= enable_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign latch_D      = data_reg;
    assign latch_enable = enable_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign err          = err_reg;

endmodule
